text_console_writer: RTL and testbench

//  Writer side of the character-overlay screen buffer. Accepts a byte stream (valid/ready) from a CPU/UART,

---
 rtl/text_console_writer.sv | 171 +++++++++++++++++
 tb/tb_text_console_writer.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/text_console_writer.sv
// Character-overlay screen writer: decodes a byte stream into cursor moves and buffer writes,
// with auto-wrap, hardware scroll (top_row offset) and blanking of rows / the whole screen.
module text_console_writer #(
    parameter int unsigned COLS   = 80,
    parameter int unsigned ROWS   = 25,
    parameter int unsigned STRIDE = 128,
    parameter logic [7:0]  BLANK  = 8'h20
) (
    input  logic        vo_clk,
    input  logic        vo_reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  in_char,
    output logic        buf_wr,
    output logic [11:0] buf_wr_addr,
    output logic [7:0]  buf_wr_data,
    output logic [4:0]  top_row,
    output logic [6:0]  cursor_x,
    output logic [4:0]  cursor_y,
    output logic        busy
);

    localparam int unsigned SW = $clog2(STRIDE);

    typedef enum logic [1:0] {CLEAR_ALL, IDLE, CLEAR_ROW} state_t;

    state_t      state, state_d;
    logic [4:0]  clr_row, clr_row_d;
    logic [6:0]  clr_col, clr_col_d;
    logic [4:0]  top_d, y_d;
    logic [6:0]  x_d;
    logic        wr_d;
    logic [11:0] addr_d;
    logic [7:0]  data_d;
    logic [5:0]  row_sum;
    logic [4:0]  phys_row;
    logic        do_nl;

    function automatic logic [11:0] addr_of(input logic [4:0] row, input logic [6:0] col);
        return (12'(row) << SW) | 12'(col);
    endfunction

    assign in_ready = (state == IDLE);
    assign busy     = ~in_ready;

    always_comb begin
        row_sum  = {1'b0, cursor_y} + {1'b0, top_row};
        phys_row = (row_sum >= 6'(ROWS)) ? 5'(row_sum - 6'(ROWS)) : row_sum[4:0];
    end

    always_comb begin
        state_d   = state;
        clr_row_d = clr_row;
        clr_col_d = clr_col;
        top_d     = top_row;
        x_d       = cursor_x;
        y_d       = cursor_y;
        wr_d      = 1'b0;
        addr_d    = buf_wr_addr;
        data_d    = buf_wr_data;
        do_nl     = 1'b0;
        case (state)
            CLEAR_ALL: begin
                if (clr_row == 5'(ROWS)) begin
                    state_d = IDLE;
                end else begin
                    wr_d   = 1'b1;
                    addr_d = addr_of(clr_row, clr_col);
                    data_d = BLANK;
                    if (clr_col == 7'(COLS - 1)) begin
                        clr_col_d = '0;
                        clr_row_d = clr_row + 5'd1;
                    end else begin
                        clr_col_d = clr_col + 7'd1;
                    end
                end
            end
            CLEAR_ROW: begin
                if (clr_col == 7'(COLS)) begin
                    state_d = IDLE;
                end else begin
                    wr_d      = 1'b1;
                    addr_d    = addr_of(clr_row, clr_col);
                    data_d    = BLANK;
                    clr_col_d = clr_col + 7'd1;
                end
            end
            IDLE: begin
                if (in_valid) begin
                    if (in_char >= 8'h20) begin
                        wr_d   = 1'b1;
                        addr_d = addr_of(phys_row, cursor_x);
                        data_d = in_char;
                        if (cursor_x == 7'(COLS - 1)) begin
                            x_d   = '0;
                            do_nl = 1'b1;
                        end else begin
                            x_d = cursor_x + 7'd1;
                        end
                    end else begin
                        case (in_char)
                            8'h0D: x_d = '0;
                            8'h0A: do_nl = 1'b1;
                            8'h08: begin
                                if (cursor_x != '0) begin
                                    x_d    = cursor_x - 7'd1;
                                    wr_d   = 1'b1;
                                    addr_d = addr_of(phys_row, cursor_x - 7'd1);
                                    data_d = BLANK;
                                end
                            end
                            8'h0C: begin
                                top_d     = '0;
                                x_d       = '0;
                                y_d       = '0;
                                clr_row_d = '0;
                                clr_col_d = '0;
                                state_d   = CLEAR_ALL;
                            end
                            default: ;
                        endcase
                    end
                    if (do_nl) begin
                        if (cursor_y < 5'(ROWS - 1)) begin
                            y_d = cursor_y + 5'd1;
                        end else begin
                            top_d     = (top_row == 5'(ROWS - 1)) ? '0 : top_row + 5'd1;
                            clr_row_d = top_row;
                            state_d   = CLEAR_ROW;
                            // A bare LF has no char write pending, so the row clear starts right away.
                            if (!wr_d) begin
                                wr_d      = 1'b1;
                                addr_d    = addr_of(top_row, '0);
                                data_d    = BLANK;
                                clr_col_d = 7'd1;
                            end else begin
                                clr_col_d = '0;
                            end
                        end
                    end
                end
            end
            default: state_d = CLEAR_ALL;
        endcase
    end

    always_ff @(posedge vo_clk) begin
        if (vo_reset) begin
            state       <= CLEAR_ALL;
            clr_row     <= '0;
            clr_col     <= '0;
            top_row     <= '0;
            cursor_x    <= '0;
            cursor_y    <= '0;
            buf_wr      <= 1'b0;
            buf_wr_addr <= '0;
            buf_wr_data <= '0;
        end else begin
            state       <= state_d;
            clr_row     <= clr_row_d;
            clr_col     <= clr_col_d;
            top_row     <= top_d;
            cursor_x    <= x_d;
            cursor_y    <= y_d;
            buf_wr      <= wr_d;
            buf_wr_addr <= addr_d;
            buf_wr_data <= data_d;
        end
    end

endmodule

// File: tb/tb_text_console_writer.sv
// Self-checking bench for text_console_writer: directed vectors, multi-cycle clear/scroll
// sequences, and randomized bytes against a screen-level reference model.
module tb_text_console_writer;

    logic        vo_clk = 1'b0;
    logic        vo_reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  in_char = 8'h00;
    logic        buf_wr;
    logic [11:0] buf_wr_addr;
    logic [7:0]  buf_wr_data;
    logic [4:0]  top_row;
    logic [6:0]  cursor_x;
    logic [4:0]  cursor_y;
    logic        busy;

    text_console_writer #(.COLS(80), .ROWS(25), .STRIDE(128), .BLANK(8'h20)) dut (
        .vo_clk(vo_clk), .vo_reset(vo_reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_char(in_char), .buf_wr(buf_wr), .buf_wr_addr(buf_wr_addr), .buf_wr_data(buf_wr_data),
        .top_row(top_row), .cursor_x(cursor_x), .cursor_y(cursor_y), .busy(busy)
    );

    always #5 vo_clk = ~vo_clk;

    int checks = 0;
    int errors = 0;

    typedef struct { logic [11:0] a; logic [7:0] d; } w_t;
    w_t wq[$];
    logic [7:0] dut_mem [4096];
    logic [7:0] mem_ref [4096];
    int m_x, m_y, m_top;

    always @(posedge vo_clk) begin
        if (buf_wr === 1'b1) begin
            wq.push_back('{a: buf_wr_addr, d: buf_wr_data});
            dut_mem[buf_wr_addr] <= buf_wr_data;
        end
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge vo_clk);
        #1;
    endtask

    task automatic wait_ready(input int maxc, input bit noise, output int n);
        n = 0;
        while (!in_ready && n < maxc) begin
            if (noise) begin
                in_valid = 1'($urandom % 2);
                in_char  = 8'($urandom);
            end
            tick();
            n++;
        end
        in_valid = 1'b0;
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL ready_timeout: in_ready still 0 after %0d cycles", n);
        end
    endtask

    task automatic send(input logic [7:0] c);
        int n;
        wait_ready(4000, 1'b0, n);
        in_valid = 1'b1;
        in_char  = c;
        tick();
        in_valid = 1'b0;
    endtask

    // Starts at the point where the clear's first write is one edge away.
    task automatic full_clear_check(input string nm);
        int n, wrs, bad;
        wq.delete();
        n = 0;
        wrs = 0;
        do begin
            tick();
            n++;
            if (!in_ready && buf_wr) wrs++;
        end while (!in_ready && n < 3000);
        check({nm, "_cycles"}, n, 2001);
        check({nm, "_wr_cycles"}, wrs, 2000);
        check({nm, "_count"}, wq.size(), 2000);
        bad = 0;
        for (int i = 0; i < wq.size() && i < 2000; i++)
            if (wq[i].a !== 12'((i / 80) * 128 + i % 80) || wq[i].d !== 8'h20) bad++;
        check({nm, "_seq_bad"}, bad, 0);
    endtask

    // Reference model: cursor, scroll offset and screen contents from the byte rules.
    task automatic model_byte(input logic [7:0] c, output bit ewr, output int ea,
                              output logic [7:0] ed, output bit eb);
        int phys, old;
        bit nl;
        phys = (m_y + m_top) % 25;
        ewr = 0; ea = 0; ed = 0; eb = 0; nl = 0;
        if (c >= 8'h20) begin
            ewr = 1; ea = phys * 128 + m_x; ed = c;
            mem_ref[ea] = c;
            m_x++;
            if (m_x == 80) begin m_x = 0; nl = 1; end
        end else if (c == 8'h0D) begin
            m_x = 0;
        end else if (c == 8'h0A) begin
            nl = 1;
        end else if (c == 8'h08) begin
            if (m_x > 0) begin
                m_x--; ewr = 1; ea = phys * 128 + m_x; ed = 8'h20;
                mem_ref[ea] = 8'h20;
            end
        end else if (c == 8'h0C) begin
            m_x = 0; m_y = 0; m_top = 0; eb = 1;
            for (int r = 0; r < 25; r++)
                for (int k = 0; k < 80; k++) mem_ref[r * 128 + k] = 8'h20;
        end
        if (nl) begin
            if (m_y < 24) m_y++;
            else begin
                old = m_top;
                m_top = (m_top + 1) % 25;
                eb = 1;
                for (int k = 0; k < 80; k++) mem_ref[old * 128 + k] = 8'h20;
                if (!ewr) begin ewr = 1; ea = old * 128; ed = 8'h20; end
            end
        end
    endtask

    typedef struct {
        logic [7:0]  c;
        logic        ewr;
        logic [11:0] ea;
        logic [7:0]  ed;
        logic [6:0]  ex;
        logic [4:0]  ey;
    } vec_t;
    vec_t vt[15];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, lowcnt, okcnt, bad;
        bit ewr, eb;
        int ea;
        logic [7:0] ed, c;

        for (int i = 0; i < 4096; i++) begin
            dut_mem[i] = 8'h00;
            mem_ref[i] = 8'h00;
        end

        // Reset state, then the power-on clear.
        repeat (3) tick();
        check("rst_buf_wr", buf_wr, 0);
        check("rst_addr", buf_wr_addr, 0);
        check("rst_data", buf_wr_data, 0);
        check("rst_top", top_row, 0);
        check("rst_x", cursor_x, 0);
        check("rst_y", cursor_y, 0);
        check("rst_ready", in_ready, 0);
        vo_reset = 1'b0;
        full_clear_check("init_clear");
        check("init_ready", in_ready, 1);
        check("init_busy", busy, 0);

        // Directed vectors from (0,0), top_row 0.
        vt[0]  = '{8'h41, 1'b1, 12'd0,   8'h41, 7'd1, 5'd0};
        vt[1]  = '{8'h42, 1'b1, 12'd1,   8'h42, 7'd2, 5'd0};
        vt[2]  = '{8'h0D, 1'b0, 12'd0,   8'h00, 7'd0, 5'd0};
        vt[3]  = '{8'h08, 1'b0, 12'd0,   8'h00, 7'd0, 5'd0};
        vt[4]  = '{8'h07, 1'b0, 12'd0,   8'h00, 7'd0, 5'd0};
        vt[5]  = '{8'h0A, 1'b0, 12'd0,   8'h00, 7'd0, 5'd1};
        vt[6]  = '{8'h43, 1'b1, 12'd128, 8'h43, 7'd1, 5'd1};
        vt[7]  = '{8'h08, 1'b1, 12'd128, 8'h20, 7'd0, 5'd1};
        vt[8]  = '{8'h0A, 1'b0, 12'd0,   8'h00, 7'd0, 5'd2};
        vt[9]  = '{8'h61, 1'b1, 12'd256, 8'h61, 7'd1, 5'd2};
        vt[10] = '{8'h62, 1'b1, 12'd257, 8'h62, 7'd2, 5'd2};
        vt[11] = '{8'hFF, 1'b1, 12'd258, 8'hFF, 7'd3, 5'd2};
        vt[12] = '{8'h08, 1'b1, 12'd258, 8'h20, 7'd2, 5'd2};
        vt[13] = '{8'h1B, 1'b0, 12'd0,   8'h00, 7'd2, 5'd2};
        vt[14] = '{8'h20, 1'b1, 12'd258, 8'h20, 7'd3, 5'd2};
        for (int i = 0; i < 15; i++) begin
            send(vt[i].c);
            check($sformatf("vec%0d_wr", i), buf_wr, vt[i].ewr);
            if (vt[i].ewr) begin
                check($sformatf("vec%0d_addr", i), buf_wr_addr, vt[i].ea);
                check($sformatf("vec%0d_data", i), buf_wr_data, vt[i].ed);
            end
            check($sformatf("vec%0d_x", i), cursor_x, vt[i].ex);
            check($sformatf("vec%0d_y", i), cursor_y, vt[i].ey);
            check($sformatf("vec%0d_top", i), top_row, 0);
        end

        // FF clears everything and homes the cursor.
        send(8'h0C);
        check("ff1_busy", busy, 1);
        full_clear_check("ff1_clear");

        // Auto-wrap at the right margin.
        for (int i = 0; i < 80; i++) send(8'h78);
        check("wrap_addr", buf_wr_addr, 79);
        check("wrap_x", cursor_x, 0);
        check("wrap_y", cursor_y, 1);
        check("wrap_ready", in_ready, 1);
        send(8'h79);
        check("wrap_next_addr", buf_wr_addr, 128);
        check("wrap_next_data", buf_wr_data, 8'h79);

        // LF on the bottom row scrolls and blanks the new bottom row.
        for (int i = 0; i < 23; i++) send(8'h0A);
        send(8'h0D);
        for (int i = 0; i < 5; i++) send(8'h71);
        check("pre_scroll_x", cursor_x, 5);
        check("pre_scroll_y", cursor_y, 24);
        send(8'h0A);
        check("scroll_top", top_row, 1);
        check("scroll_x", cursor_x, 5);
        check("scroll_y", cursor_y, 24);
        check("scroll_ready", in_ready, 0);
        lowcnt = 0;
        okcnt = 0;
        while (!in_ready && lowcnt < 200) begin
            if (buf_wr && buf_wr_addr == 12'(lowcnt) && buf_wr_data == 8'h20) okcnt++;
            lowcnt++;
            tick();
        end
        check("scroll_busy_cycles", lowcnt, 80);
        check("scroll_clear_writes", okcnt, 80);
        send(8'h0D);
        send(8'h5A);
        check("scroll_z_wr", buf_wr, 1);
        check("scroll_z_addr", buf_wr_addr, 0);
        check("scroll_z_data", buf_wr_data, 8'h5A);
        check("scroll_z_x", cursor_x, 1);
        check("scroll_z_y", cursor_y, 24);

        // Scroll up to top_row 5, then FF and a reset in the middle of the clear.
        for (int i = 0; i < 4; i++) begin
            send(8'h0A);
            wait_ready(200, 1'b0, n);
        end
        check("top5", top_row, 5);
        send(8'h0C);
        check("ff2_top", top_row, 0);
        check("ff2_x", cursor_x, 0);
        check("ff2_y", cursor_y, 0);
        check("ff2_ready", in_ready, 0);
        repeat (500) tick();
        check("midclear_wr", buf_wr, 1);
        vo_reset = 1'b1;
        tick();
        check("midrst_wr0", buf_wr, 0);
        check("midrst_addr", buf_wr_addr, 0);
        tick();
        check("midrst_wr1", buf_wr, 0);
        check("midrst_ready", in_ready, 0);
        vo_reset = 1'b0;
        full_clear_check("rst_clear");

        // Randomized bytes against the reference model.
        m_x = 0; m_y = 0; m_top = 0;
        for (int i = 0; i < 4096; i++) mem_ref[i] = dut_mem[i];
        for (int r = 0; r < 25; r++)
            for (int k = 0; k < 128; k++) mem_ref[r * 128 + k] = (k < 80) ? 8'h20 : 8'h00;
        for (int i = 0; i < 800; i++) begin
            n = int'($urandom % 100);
            if (n < 55)      c = 8'($urandom_range(32, 255));
            else if (n < 65) c = 8'h0D;
            else if (n < 80) c = 8'h0A;
            else if (n < 88) c = 8'h08;
            else if (n < 89) c = 8'h0C;
            else             c = 8'($urandom_range(0, 31));
            model_byte(c, ewr, ea, ed, eb);
            if ($urandom % 4 == 0) repeat ($urandom_range(1, 3)) tick();
            send(c);
            check("rnd_wr", buf_wr, ewr);
            if (ewr) begin
                check("rnd_addr", buf_wr_addr, ea);
                check("rnd_data", buf_wr_data, ed);
            end
            check("rnd_x", cursor_x, m_x);
            check("rnd_y", cursor_y, m_y);
            check("rnd_top", top_row, m_top);
            check("rnd_ready", in_ready, !eb);
            if (eb) wait_ready(2100, 1'b1, n);
        end
        tick();
        bad = 0;
        for (int i = 0; i < 4096; i++) if (dut_mem[i] !== mem_ref[i]) bad++;
        check("rnd_screen_bad", bad, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
